// File: rtl/uart_frame_bridge_if.sv
// uart_frame_bridge_if
//   Groups the bus master, slave-forward and UART core signals of the
//   uart_frame_bridge into one bundle.
//   Ports/signals:
//     m_tx_done, m_rx_done, m_data_in        bus master completion + read data
//     m_instruction, m_slave_select,
//     m_address, m_data_out                  bus master request
//     s_data, s_write_en_in                  slave data to forward over UART
//     u_tx_done, u_receive_sig, u_data_in    UART core status + received byte
//     u_send_sig, u_data_out                 UART core send request + byte
//     frame_error                            aborted/rejected frame pulse
//   Modports: master = bridge side, slave = environment side.
//   Parameters must match those of the connected uart_frame_bridge.
interface uart_frame_bridge_if #(
   parameter int unsigned SLAVE_LEN = 2,
   parameter int unsigned ADDR_LEN  = 12,
   parameter int unsigned DATA_LEN  = 8
);
   logic                 m_tx_done;
   logic                 m_rx_done;
   logic [DATA_LEN-1:0]  m_data_in;
   logic [1:0]           m_instruction;
   logic [SLAVE_LEN-1:0] m_slave_select;
   logic [ADDR_LEN-1:0]  m_address;
   logic [DATA_LEN-1:0]  m_data_out;
   logic [7:0]           s_data;
   logic                 s_write_en_in;
   logic                 u_tx_done;
   logic                 u_receive_sig;
   logic [7:0]           u_data_in;
   logic                 u_send_sig;
   logic [7:0]           u_data_out;
   logic                 frame_error;

   modport master (
      input  m_tx_done, m_rx_done, m_data_in,
      input  s_data, s_write_en_in,
      input  u_tx_done, u_receive_sig, u_data_in,
      output m_instruction, m_slave_select, m_address, m_data_out,
      output u_send_sig, u_data_out, frame_error
   );

   modport slave (
      output m_tx_done, m_rx_done, m_data_in,
      output s_data, s_write_en_in,
      output u_tx_done, u_receive_sig, u_data_in,
      input  m_instruction, m_slave_select, m_address, m_data_out,
      input  u_send_sig, u_data_out, frame_error
   );
endinterface

// File: rtl/uart_frame_bridge.sv
// uart_frame_bridge
//   Decodes framed UART commands (CMD, ADDR_H, ADDR_L, [DATA]) into bus
//   master read/write transactions and answers with ACK/NAK or read data.
//   Also forwards slave write data to UART with ACK-timeout and retry.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high
//     bus    uart_frame_bridge_if.master (bus master, slave forward, UART)
//   Optional feature macro: UART_FRAME_TIMEOUT_EN
//     defined   -> a partial frame idle for MAX_COUNT cycles is dropped and
//                  frame_error pulses (no NAK sent)
//     undefined -> partial frames wait indefinitely
module uart_frame_bridge #(
   parameter int unsigned SLAVE_LEN = 2,
   parameter int unsigned ADDR_LEN  = 12,
   parameter int unsigned DATA_LEN  = 8,
   parameter int unsigned MAX_COUNT = 50000,
   parameter int unsigned MAX_RETRY = 5,
   parameter int unsigned ACK_BYTE  = 204,
   parameter int unsigned NAK_BYTE  = 51
) (
   input logic                 clk,
   input logic                 reset,
   uart_frame_bridge_if.master bus
);

   localparam int unsigned CNT_W   = $clog2(MAX_COUNT + 1);
   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
   localparam logic [1:0]  OP_WRITE = 2'b10;
   localparam logic [1:0]  OP_READ  = 2'b01;

   typedef enum logic [2:0] {
      C_CMD, C_ADDR_H, C_ADDR_L, C_DATA, C_ISSUE, C_WAIT_BUS
   } cmd_state_t;

   typedef enum logic [2:0] {
      T_IDLE, T_SEND, T_WAIT_DONE, T_ACK_IN, T_HOLD
   } tx_state_t;

   cmd_state_t           cmd_state, cmd_next;
   tx_state_t            tx_state, tx_next;

   logic [1:0]           op_q;
   logic [SLAVE_LEN-1:0] slave_q;
   logic [7:0]           addr_h_q, addr_l_q;
   logic [DATA_LEN-1:0]  wdata_q;

   logic                 slot_full;
   logic [7:0]           slot_data;

   logic [7:0]           tx_byte;
   logic                 tx_is_fwd;
   logic [RETRY_W-1:0]   attempts;
   logic [CNT_W-1:0]     ack_cnt;
   logic                 frame_err_q;

   logic                 rx_cmd;
   logic                 op_valid;
   logic                 bus_done;
   logic                 nak_req;
   logic                 resp_set;
   logic                 ack_rx;
   logic                 other_rx;
   logic                 ack_timeout;
   logic                 frame_timeout;

   // While waiting for a forward ACK every received byte belongs to the
   // TX side; the command decoder never sees it.
   assign rx_cmd   = bus.u_receive_sig && (tx_state != T_ACK_IN);
   assign op_valid = (bus.u_data_in[7:6] == OP_WRITE) || (bus.u_data_in[7:6] == OP_READ);
   assign bus_done = (cmd_state == C_WAIT_BUS) &&
                     (((op_q == OP_WRITE) && bus.m_tx_done) ||
                      ((op_q == OP_READ)  && bus.m_rx_done));
   assign nak_req  = (cmd_state == C_CMD) && rx_cmd && !op_valid;
   // A NAK arriving while the slot still holds an unsent response is dropped.
   assign resp_set = bus_done || (nak_req && !slot_full);

   assign ack_rx      = bus.u_receive_sig && (bus.u_data_in == 8'(ACK_BYTE));
   assign other_rx    = bus.u_receive_sig && (bus.u_data_in != 8'(ACK_BYTE));
   assign ack_timeout = (ack_cnt == CNT_W'(MAX_COUNT));

`ifdef UART_FRAME_TIMEOUT_EN
   logic             in_frame;
   logic [CNT_W-1:0] frame_cnt;

   assign in_frame      = (cmd_state == C_ADDR_H) || (cmd_state == C_ADDR_L) ||
                          (cmd_state == C_DATA);
   assign frame_timeout = in_frame && !rx_cmd && (frame_cnt == CNT_W'(MAX_COUNT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (!in_frame || rx_cmd) begin
         frame_cnt <= '0;
      end else begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end
`else
   assign frame_timeout = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Command FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_state <= C_CMD;
      end else begin
         cmd_state <= cmd_next;
      end
   end

   always_comb begin
      cmd_next = cmd_state;
      unique case (cmd_state)
         C_CMD: begin
            if (rx_cmd && op_valid) cmd_next = C_ADDR_H;
         end
         C_ADDR_H: begin
            if (frame_timeout)  cmd_next = C_CMD;
            else if (rx_cmd)    cmd_next = C_ADDR_L;
         end
         C_ADDR_L: begin
            if (frame_timeout)  cmd_next = C_CMD;
            else if (rx_cmd)    cmd_next = (op_q == OP_WRITE) ? C_DATA : C_ISSUE;
         end
         C_DATA: begin
            if (frame_timeout)  cmd_next = C_CMD;
            else if (rx_cmd)    cmd_next = C_ISSUE;
         end
         C_ISSUE: begin
            if (!slot_full) cmd_next = C_WAIT_BUS;
         end
         C_WAIT_BUS: begin
            if (bus_done) cmd_next = C_CMD;
         end
         default: cmd_next = C_CMD;
      endcase
   end

   // The request is presented combinationally from C_ISSUE so it is valid
   // the cycle after the final frame byte, and drops the cycle after done.
   always_comb begin
      bus.m_instruction = 2'b00;
      if (((cmd_state == C_ISSUE) && !slot_full) || (cmd_state == C_WAIT_BUS)) begin
         bus.m_instruction = op_q;
      end
   end

   assign bus.m_slave_select = slave_q;
   assign bus.m_address      = ADDR_LEN'({addr_h_q, addr_l_q});
   assign bus.m_data_out     = wdata_q;
   assign bus.frame_error    = frame_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q        <= '0;
         slave_q     <= '0;
         addr_h_q    <= '0;
         addr_l_q    <= '0;
         wdata_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= nak_req || frame_timeout;
         if (rx_cmd) begin
            unique case (cmd_state)
               C_CMD: begin
                  if (op_valid) begin
                     op_q    <= bus.u_data_in[7:6];
                     slave_q <= bus.u_data_in[SLAVE_LEN-1:0];
                  end
               end
               C_ADDR_H: addr_h_q <= bus.u_data_in;
               C_ADDR_L: addr_l_q <= bus.u_data_in;
               C_DATA:   wdata_q  <= bus.u_data_in;
               default: ;
            endcase
         end
      end
   end

   // Single-entry response slot shared between the two FSMs. Set and clear
   // are exclusive: completions and NAKs only land while it is empty and the
   // TX side only clears it while it is full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_full <= 1'b0;
         slot_data <= '0;
      end else if (resp_set) begin
         slot_full <= 1'b1;
         if (bus_done) begin
            slot_data <= (op_q == OP_WRITE) ? 8'(ACK_BYTE) : bus.m_data_in;
         end else begin
            slot_data <= 8'(NAK_BYTE);
         end
      end else if ((tx_state == T_IDLE) && slot_full) begin
         slot_full <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // TX FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state <= T_IDLE;
      end else begin
         tx_state <= tx_next;
      end
   end

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         T_IDLE: begin
            if (slot_full || bus.s_write_en_in) tx_next = T_SEND;
         end
         T_SEND: tx_next = T_WAIT_DONE;
         T_WAIT_DONE: begin
            if (bus.u_tx_done) tx_next = tx_is_fwd ? T_ACK_IN : T_IDLE;
         end
         T_ACK_IN: begin
            if (ack_rx) begin
               tx_next = bus.s_write_en_in ? T_HOLD : T_IDLE;
            end else if (other_rx || ack_timeout) begin
               if (attempts < RETRY_W'(MAX_RETRY)) tx_next = T_SEND;
               else tx_next = bus.s_write_en_in ? T_HOLD : T_IDLE;
            end
         end
         T_HOLD: begin
            if (!bus.s_write_en_in) tx_next = T_IDLE;
         end
         default: tx_next = T_IDLE;
      endcase
   end

   always_comb begin
      bus.u_send_sig = (tx_state == T_SEND);
      bus.u_data_out = tx_byte;
   end

   // ack_cnt is zero on the first T_ACK_IN cycle and leaves the state no
   // later than MAX_COUNT, so it never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_byte   <= '0;
         tx_is_fwd <= 1'b0;
         attempts  <= '0;
         ack_cnt   <= '0;
      end else begin
         if (tx_state == T_IDLE) begin
            if (slot_full) begin
               tx_byte   <= slot_data;
               tx_is_fwd <= 1'b0;
            end else if (bus.s_write_en_in) begin
               tx_byte   <= bus.s_data;
               tx_is_fwd <= 1'b1;
               attempts  <= RETRY_W'(1);
            end
         end
         if ((tx_state == T_ACK_IN) && (tx_next == T_SEND)) begin
            attempts <= attempts + 1'b1;
         end
         if (tx_state == T_ACK_IN) begin
            ack_cnt <= ack_cnt + 1'b1;
         end else begin
            ack_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_bridge.sv
// tb_uart_frame_bridge
//   Self-checking bench for uart_frame_bridge: table-driven frame vectors,
//   a byte scoreboard on the UART send side, and hand-written sequences for
//   slave forwarding, retry/timeout, arbitration, frame timeout and reset.
module tb_uart_frame_bridge;
   localparam int unsigned MC     = 20;
   localparam int unsigned MR     = 5;
   localparam int unsigned TX_LAT = 2;
   // send in cycle S, u_tx_done high in S+TX_LAT, T_ACK_IN from S+TX_LAT+1,
   // resend MC+1 cycles after entering T_ACK_IN
   localparam int EXP_GAP = TX_LAT + 1 + MC + 1;

   typedef struct {
      logic [7:0]  b0, b1, b2, b3;
      int          kind;            // 0 write, 1 read, 2 invalid op
      logic [7:0]  rdata;
      logic [1:0]  instr;
      logic [1:0]  slave;
      logic [11:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  resp;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_frame_bridge_if #(.SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8)) bus_if ();

   uart_frame_bridge #(
      .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8),
      .MAX_COUNT(MC), .MAX_RETRY(MR), .ACK_BYTE(204), .NAK_BYTE(51)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.master)
   );

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         n_sends = 0;
   int         fe_count = 0;
   int         send_cyc[$];
   logic [7:0] exp_q[$];
   logic       prev_send = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Send-side scoreboard and frame_error counter
   initial begin
      forever begin
         @(negedge clk);
         if (bus_if.frame_error) fe_count++;
         if (bus_if.u_send_sig) begin
            check("send_one_cycle", {31'd0, prev_send}, 32'd0);
            n_sends++;
            send_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_send: got 0x%0h expected none", bus_if.u_data_out);
            end else begin
               check("tx_byte", {24'd0, bus_if.u_data_out}, {24'd0, exp_q.pop_front()});
            end
         end
         prev_send = bus_if.u_send_sig;
      end
   end

   // UART core model: acknowledges each send TX_LAT cycles later
   initial begin
      logic [7:0] held;
      bus_if.u_tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.u_send_sig) begin
            held = bus_if.u_data_out;
            repeat (TX_LAT) @(posedge clk);
            #1 bus_if.u_tx_done = 1'b1;
            check("data_stable", {24'd0, bus_if.u_data_out}, {24'd0, held});
            @(posedge clk);
            #1 bus_if.u_tx_done = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus_if.u_data_in     = b;
      bus_if.u_receive_sig = 1'b1;
      @(negedge clk);
      bus_if.u_receive_sig = 1'b0;
   endtask

   task automatic wait_sends(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (n_sends < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_reached"}, {31'd0, n_sends >= target}, 32'd1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_drained"}, exp_q.size(), 32'd0);
      repeat (TX_LAT + 3) @(negedge clk);
   endtask

   // reply to a forward send while the bridge sits in T_ACK_IN
   task automatic reply_in_ack(input logic [7:0] b);
      repeat (TX_LAT + 1) @(negedge clk);
      send_byte(b);
   endtask

   task automatic apply_vec(input vec_t v, input int skip);
      int fe0, dcyc;
      fe0 = fe_count;
      if (v.kind == 2) begin
         exp_q.push_back(v.resp);
         send_byte(v.b0);
         repeat (2) @(negedge clk);
         #1;
         check("bad_op_frame_error", fe_count - fe0, 32'd1);
         check("bad_op_no_request", {30'd0, bus_if.m_instruction}, 32'd0);
         drain("nak");
      end else begin
         if (skip < 1) send_byte(v.b0);
         if (skip < 2) send_byte(v.b1);
         send_byte(v.b2);
         if (v.kind == 0) send_byte(v.b3);
         check("m_instruction", {30'd0, bus_if.m_instruction}, {30'd0, v.instr});
         check("m_slave_select", {30'd0, bus_if.m_slave_select}, {30'd0, v.slave});
         check("m_address", {20'd0, bus_if.m_address}, {20'd0, v.addr});
         if (v.kind == 0) check("m_data_out", {24'd0, bus_if.m_data_out}, {24'd0, v.wdata});
         @(negedge clk);
         check("m_instruction_hold", {30'd0, bus_if.m_instruction}, {30'd0, v.instr});
         exp_q.push_back(v.resp);
         dcyc = cyc;
         if (v.kind == 0) begin
            bus_if.m_tx_done = 1'b1;
         end else begin
            bus_if.m_rx_done = 1'b1;
            bus_if.m_data_in = v.rdata;
         end
         @(negedge clk);
         bus_if.m_tx_done = 1'b0;
         bus_if.m_rx_done = 1'b0;
         check("m_instruction_cleared", {30'd0, bus_if.m_instruction}, 32'd0);
         drain("resp");
         check("resp_latency", send_cyc[$] - dcyc, 32'd2);
         check("valid_no_frame_error", fe_count - fe0, 32'd0);
      end
   endtask

   initial begin
      vec_t vecs[7];
      int   base, fe0, dcyc;

      bus_if.m_tx_done     = 1'b0;
      bus_if.m_rx_done     = 1'b0;
      bus_if.m_data_in     = '0;
      bus_if.s_data        = '0;
      bus_if.s_write_en_in = 1'b0;
      bus_if.u_receive_sig = 1'b0;
      bus_if.u_data_in     = '0;

      vecs[0] = '{8'h81, 8'h01, 8'h23, 8'h5A, 0, 8'h00, 2'b10, 2'd1, 12'h123, 8'h5A, 8'd204};
      vecs[1] = '{8'h40, 8'h00, 8'h10, 8'h00, 1, 8'h77, 2'b01, 2'd0, 12'h010, 8'h00, 8'h77};
      vecs[2] = '{8'hC0, 8'h00, 8'h00, 8'h00, 2, 8'h00, 2'b00, 2'd0, 12'h000, 8'h00, 8'd51};
      vecs[3] = '{8'h83, 8'hFA, 8'hBC, 8'hFF, 0, 8'h00, 2'b10, 2'd3, 12'hABC, 8'hFF, 8'd204};
      vecs[4] = '{8'h7E, 8'h0F, 8'hFF, 8'h00, 1, 8'h00, 2'b01, 2'd2, 12'hFFF, 8'h00, 8'h00};
      vecs[5] = '{8'h01, 8'h00, 8'h00, 8'h00, 2, 8'h00, 2'b00, 2'd0, 12'h000, 8'h00, 8'd51};
      vecs[6] = '{8'h41, 8'h12, 8'h34, 8'h00, 1, 8'hCC, 2'b01, 2'd1, 12'h234, 8'h00, 8'hCC};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_m_instruction", {30'd0, bus_if.m_instruction}, 32'd0);
      check("rst_u_send_sig", {31'd0, bus_if.u_send_sig}, 32'd0);
      check("rst_frame_error", {31'd0, bus_if.frame_error}, 32'd0);
      check("rst_m_address", {20'd0, bus_if.m_address}, 32'd0);
      check("rst_u_data_out", {24'd0, bus_if.u_data_out}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) apply_vec(vecs[i], 0);

      // slave forward without ACK: MR attempts spaced by the timeout, then hold
      fe0  = fe_count;
      base = n_sends;
      repeat (MR) exp_q.push_back(8'h3C);
      @(negedge clk);
      bus_if.s_data        = 8'h3C;
      bus_if.s_write_en_in = 1'b1;
      wait_sends(base + 1, 20, "fwd_first");
      bus_if.s_data = 8'h99;
      wait_sends(base + MR, MR * EXP_GAP + 20, "fwd_retry");
      repeat (2 * EXP_GAP) @(negedge clk);
      #1;
      check("retry_count", n_sends - base, MR);
      for (int k = 1; k < int'(MR); k++) begin
         check("retry_gap", send_cyc[base + k] - send_cyc[base + k - 1], EXP_GAP);
      end
      bus_if.s_write_en_in = 1'b0;
      repeat (5) @(negedge clk);

      // forward ACKed after the first send: exactly one send
      base = n_sends;
      exp_q.push_back(8'h3C);
      bus_if.s_data        = 8'h3C;
      bus_if.s_write_en_in = 1'b1;
      wait_sends(base + 1, 20, "fwd_ack");
      reply_in_ack(8'd204);
      bus_if.s_write_en_in = 1'b0;
      repeat (2 * EXP_GAP) @(negedge clk);
      #1;
      check("ack_single_send", n_sends - base, 32'd1);

      // non-ACK reply triggers an immediate resend, then ACK ends it
      base = n_sends;
      exp_q.push_back(8'hE7);
      exp_q.push_back(8'hE7);
      bus_if.s_data        = 8'hE7;
      bus_if.s_write_en_in = 1'b1;
      wait_sends(base + 1, 20, "fwd_nak");
      reply_in_ack(8'd51);
      wait_sends(base + 2, 20, "fwd_resend");
      check("nak_resend_gap", send_cyc[base + 1] - send_cyc[base], TX_LAT + 3);
      reply_in_ack(8'd204);
      bus_if.s_write_en_in = 1'b0;
      repeat (2 * EXP_GAP) @(negedge clk);
      #1;
      check("nak_then_ack_sends", n_sends - base, 32'd2);
      check("ack_bytes_not_decoded", fe_count - fe0, 32'd0);

      // command decoder still idle after the TX-owned bytes
      apply_vec(vecs[1], 0);

      // response and forward request compete in T_IDLE: response first
      base = n_sends;
      send_byte(8'h82);
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h11);
      check("arb_m_instruction", {30'd0, bus_if.m_instruction}, 32'd2);
      exp_q.push_back(8'd204);
      exp_q.push_back(8'h3C);
      @(negedge clk);
      dcyc = cyc;
      bus_if.m_tx_done = 1'b1;
      @(negedge clk);
      bus_if.m_tx_done     = 1'b0;
      bus_if.s_data        = 8'h3C;
      bus_if.s_write_en_in = 1'b1;
      wait_sends(base + 1, 20, "arb_resp");
      check("arb_resp_latency", send_cyc[base] - dcyc, 32'd2);
      wait_sends(base + 2, 40, "arb_fwd");
      reply_in_ack(8'd204);
      bus_if.s_write_en_in = 1'b0;
      repeat (2 * EXP_GAP) @(negedge clk);
      #1;
      check("arb_sends", n_sends - base, 32'd2);

      // partial frame followed by silence
      fe0 = fe_count;
      send_byte(8'h81);
      send_byte(8'h01);
      repeat (MC + 5) @(negedge clk);
      #1;
`ifdef UART_FRAME_TIMEOUT_EN
      check("frame_timeout_error", fe_count - fe0, 32'd1);
      check("frame_timeout_idle", {30'd0, bus_if.m_instruction}, 32'd0);
      apply_vec(vecs[0], 0);
`else
      check("no_frame_timeout", fe_count - fe0, 32'd0);
      apply_vec(vecs[0], 2);
`endif

      // reset while the bus transaction is outstanding
      send_byte(8'h81);
      send_byte(8'h02);
      send_byte(8'h34);
      send_byte(8'h56);
      check("pre_reset_m_instruction", {30'd0, bus_if.m_instruction}, 32'd2);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_m_instruction", {30'd0, bus_if.m_instruction}, 32'd0);
      check("mid_rst_m_address", {20'd0, bus_if.m_address}, 32'd0);
      check("mid_rst_m_data_out", {24'd0, bus_if.m_data_out}, 32'd0);
      check("mid_rst_u_send_sig", {31'd0, bus_if.u_send_sig}, 32'd0);
      check("mid_rst_frame_error", {31'd0, bus_if.frame_error}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      base = n_sends;
      @(negedge clk);
      bus_if.m_tx_done = 1'b1;
      @(negedge clk);
      bus_if.m_tx_done = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("reset_no_response", n_sends - base, 32'd0);
      apply_vec(vecs[6], 0);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
